// File: rtl/mod_adder_pipe.sv
// Two-stage modular adder-subtractor on a valid/ready stream.
// S1 captures the raw (WIDTH+1)-bit sum or difference; S2 folds it back into [0, MODULUS).
module mod_adder_pipe #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             add,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             wrap,
    output logic             range_err
);
    localparam bit             MOD_EN = (MODULUS != 0);
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_raw_q,   s1_raw_d;
    logic             s1_err_q,   s1_err_d;
    logic             s1_add_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic             wrap_q,     wrap_d;
    logic             rerr_q,     rerr_d;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    assign a_ext = {1'b0, A};
    assign b_ext = {1'b0, B};

    // For subtraction the top bit of the raw result is the borrow.
    always_comb begin
        s1_raw_d = add ? (a_ext + b_ext) : (a_ext - b_ext);
        s1_err_d = MOD_EN && ((a_ext >= MOD_W) || (b_ext >= MOD_W));
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s2_load)
            s2_valid_d = 1'b1;
        else if (out_ready)
            s2_valid_d = 1'b0;
    end

    // Operands below MODULUS keep the raw value within one modulus of range, so a
    // single add or subtract of MODULUS is enough to correct it.
    always_comb begin
        sum_d  = s1_raw_q[WIDTH-1:0];
        wrap_d = 1'b0;
        rerr_d = 1'b0;
        if (!MOD_EN) begin
            wrap_d = s1_raw_q[WIDTH];
        end else if (s1_err_q) begin
            sum_d  = '0;
            rerr_d = 1'b1;
        end else if (s1_add_q) begin
            if (s1_raw_q >= MOD_W) begin
                sum_d  = WIDTH'(s1_raw_q - MOD_W);
                wrap_d = 1'b1;
            end
        end else if (s1_raw_q[WIDTH]) begin
            sum_d  = WIDTH'(s1_raw_q + MOD_W);
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_raw_q <= '0;
            s1_err_q <= 1'b0;
            s1_add_q <= 1'b0;
        end else if (s1_load) begin
            s1_raw_q <= s1_raw_d;
            s1_err_q <= s1_err_d;
            s1_add_q <= add;
        end
    end

    // Result registers only move on a stage-2 load, so a stalled result stays put.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            wrap_q <= 1'b0;
            rerr_q <= 1'b0;
        end else if (s2_load) begin
            sum_q  <= sum_d;
            wrap_q <= wrap_d;
            rerr_q <= rerr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign wrap      = wrap_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Bench for mod_adder_pipe: one instance with MODULUS=26 (index 0), one with MODULUS=0 (index 1),
// checked by directed scenarios and a random stream against an arithmetic reference model.
module tb_mod_adder_pipe;
    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [1:0]      iv_s  = '0;
    logic [1:0]      add_s = '0;
    logic [1:0]      or_s  = '1;
    logic [1:0][7:0] a_s   = '0;
    logic [1:0][7:0] b_s   = '0;
    wire  [1:0]      ir_s;
    wire  [1:0]      ov_s;
    wire  [1:0]      wrap_s;
    wire  [1:0]      err_s;
    wire  [1:0][7:0] sum_s;

    int compared   = 0;
    int mismatched = 0;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [9:0] e0, e1;

    always #5 clock = ~clock;

    mod_adder_pipe #(.WIDTH(8), .MODULUS(26)) u_m26 (
        .clock(clock), .reset(reset),
        .in_valid(iv_s[0]), .in_ready(ir_s[0]),
        .A(a_s[0]), .B(b_s[0]), .add(add_s[0]),
        .out_valid(ov_s[0]), .out_ready(or_s[0]),
        .sum(sum_s[0]), .wrap(wrap_s[0]), .range_err(err_s[0])
    );

    mod_adder_pipe #(.WIDTH(8), .MODULUS(0)) u_m0 (
        .clock(clock), .reset(reset),
        .in_valid(iv_s[1]), .in_ready(ir_s[1]),
        .A(a_s[1]), .B(b_s[1]), .add(add_s[1]),
        .out_valid(ov_s[1]), .out_ready(or_s[1]),
        .sum(sum_s[1]), .wrap(wrap_s[1]), .range_err(err_s[1])
    );

    // Reference result as {range_err, wrap, sum}, from plain integer arithmetic.
    function automatic logic [9:0] model(input int a, input int b, input bit ad, input int m);
        int r;
        if (m != 0 && (a >= m || b >= m))
            return {2'b10, 8'd0};
        if (ad) begin
            r = a + b;
            if (m == 0)
                return {1'b0, (r >= 256), 8'(r % 256)};
            if (r >= m)
                return {2'b01, 8'(r - m)};
            return {2'b00, 8'(r)};
        end
        r = a - b;
        if (r < 0)
            return {2'b01, 8'(r + ((m == 0) ? 256 : m))};
        return {2'b00, 8'(r)};
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (ov_s[0] && or_s[0]) begin
                compared++;
                if (exp_q0.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_m26_extra: got sum=%0d with nothing expected", sum_s[0]);
                end else begin
                    e0 = exp_q0.pop_front();
                    if ({err_s[0], wrap_s[0], sum_s[0]} !== e0) begin
                        mismatched++;
                        $display("FAIL sb_m26: got err/wrap/sum=%0d/%0d/%0d want %0d/%0d/%0d",
                                 err_s[0], wrap_s[0], sum_s[0], e0[9], e0[8], e0[7:0]);
                    end
                end
            end
            if (iv_s[0] && ir_s[0])
                exp_q0.push_back(model(a_s[0], b_s[0], add_s[0], 26));
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (ov_s[1] && or_s[1]) begin
                compared++;
                if (exp_q1.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_m0_extra: got sum=%0d with nothing expected", sum_s[1]);
                end else begin
                    e1 = exp_q1.pop_front();
                    if ({err_s[1], wrap_s[1], sum_s[1]} !== e1) begin
                        mismatched++;
                        $display("FAIL sb_m0: got err/wrap/sum=%0d/%0d/%0d want %0d/%0d/%0d",
                                 err_s[1], wrap_s[1], sum_s[1], e1[9], e1[8], e1[7:0]);
                    end
                end
            end
            if (iv_s[1] && ir_s[1])
                exp_q1.push_back(model(a_s[1], b_s[1], add_s[1], 0));
        end
    end

    // Drive one transaction from posedge+1; returns out_valid one edge after accept
    // and {out_valid, range_err, wrap, sum} two edges after accept.
    task automatic run_one(input int d, input logic [7:0] a, input logic [7:0] b, input bit ad,
                           output logic lat1, output logic [10:0] obs);
        bit ok = 0;
        a_s[d] = a; b_s[d] = b; add_s[d] = ad; iv_s[d] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ir_s[d]) begin ok = 1; break; end
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: in_ready stayed %0d on dut %0d", ir_s[d], d);
        end
        @(posedge clock); #1;
        iv_s[d] = 1'b0;
        lat1 = ov_s[d];
        @(posedge clock); #1;
        obs = {ov_s[d], err_s[d], wrap_s[d], sum_s[d]};
    endtask

    task automatic drain();
        iv_s = '0; or_s = '1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
        end
        compared++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            mismatched++;
            $display("FAIL drain: outstanding m26=%0d m0=%0d want 0/0", exp_q0.size(), exp_q1.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        iv_s = '0; or_s = '1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({ov_s[d], err_s[d], wrap_s[d], sum_s[d]} !== 11'd0) begin
                mismatched++;
                $display("FAIL reset_outputs[%0d]: got ov/err/wrap/sum=%0d/%0d/%0d/%0d want 0/0/0/0",
                         d, ov_s[d], err_s[d], wrap_s[d], sum_s[d]);
            end
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (ir_s[d] !== 1'b1 || ov_s[d] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_ready[%0d]: got in_ready=%0d out_valid=%0d want 1/0", d, ir_s[d], ov_s[d]);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_mod26_directed();
        logic [7:0]  ta[7], tb[7];
        bit          tad[7];
        logic [10:0] texp[7];
        logic        lat1;
        logic [10:0] obs;
        ta = '{25, 10, 3, 0, 7, 26, 4};
        tb = '{1, 5, 5, 25, 7, 0, 5};
        tad = '{1, 1, 0, 0, 0, 1, 1};
        texp = '{{3'b101, 8'd0}, {3'b100, 8'd15}, {3'b101, 8'd24}, {3'b101, 8'd1},
                 {3'b100, 8'd0}, {3'b110, 8'd0}, {3'b100, 8'd9}};
        or_s[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_one(0, ta[i], tb[i], tad[i], lat1, obs);
            compared++;
            if (lat1 !== 1'b0 || obs !== texp[i]) begin
                mismatched++;
                $display("FAIL m26_case%0d: got early_valid=%0d ov/err/wrap/sum=%0d/%0d/%0d/%0d want 0 %0d/%0d/%0d/%0d",
                         i, lat1, obs[10], obs[9], obs[8], obs[7:0],
                         texp[i][10], texp[i][9], texp[i][8], texp[i][7:0]);
            end
        end
        drain();
    endtask

    task automatic test_mod0_directed();
        logic [7:0]  ta[3], tb[3];
        bit          tad[3];
        logic [10:0] texp[3];
        logic        lat1;
        logic [10:0] obs;
        ta = '{200, 5, 255};
        tb = '{100, 10, 0};
        tad = '{1, 0, 1};
        texp = '{{3'b101, 8'd44}, {3'b101, 8'd251}, {3'b100, 8'd255}};
        or_s[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_one(1, ta[i], tb[i], tad[i], lat1, obs);
            compared++;
            if (lat1 !== 1'b0 || obs !== texp[i]) begin
                mismatched++;
                $display("FAIL m0_case%0d: got early_valid=%0d ov/err/wrap/sum=%0d/%0d/%0d/%0d want 0 %0d/%0d/%0d/%0d",
                         i, lat1, obs[10], obs[9], obs[8], obs[7:0],
                         texp[i][10], texp[i][9], texp[i][8], texp[i][7:0]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        or_s = '1;
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 2; d++) begin
                iv_s[d] = 1'b1; add_s[d] = i[0];
                a_s[d] = 8'($urandom_range(0, 25)); b_s[d] = 8'($urandom_range(0, 25));
            end
            @(negedge clock);
            if (ir_s !== 2'b11) drops++;
            if (i >= 2 && ov_s !== 2'b11) drops++;
            @(posedge clock); #1;
        end
        compared++;
        if (drops != 0) begin
            mismatched++;
            $display("FAIL back_to_back: got %0d cycles without full throughput want 0", drops);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int   idx = 0;
        int   stall = 0;
        bit   in_hs;
        logic [7:0] got[$];
        iv_s[0] = 1'b1; add_s[0] = 1'b1; a_s[0] = 8'd1; b_s[0] = 8'd1;
        or_s[0] = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            @(negedge clock);
            if (idx == 2 && or_s[0] == 1'b0) begin
                compared++;
                if (ir_s[0] !== 1'b0 || ov_s[0] !== 1'b1 || sum_s[0] !== 8'd2) begin
                    mismatched++;
                    $display("FAIL bp_stall%0d: got in_ready=%0d out_valid=%0d sum=%0d want 0/1/2",
                             stall, ir_s[0], ov_s[0], sum_s[0]);
                end
                stall++;
            end
            if (ov_s[0] && or_s[0]) got.push_back(sum_s[0]);
            in_hs = iv_s[0] && ir_s[0];
            @(posedge clock); #1;
            if (in_hs) begin
                idx++;
                if (idx < 4) begin
                    a_s[0] = 8'(idx + 1); b_s[0] = 8'(idx + 1);
                end else begin
                    iv_s[0] = 1'b0;
                end
            end
            if (stall >= 4) or_s[0] = 1'b1;
        end
        compared++;
        if (stall != 4 || got.size() != 4) begin
            mismatched++;
            $display("FAIL bp_count: got stalls=%0d results=%0d want 4/4", stall, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (got[i] !== 8'(2 * (i + 1))) begin
                    mismatched++;
                    $display("FAIL bp_order%0d: got %0d want %0d", i, got[i], 2 * (i + 1));
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic        lat1;
        logic [10:0] obs;
        or_s[0] = 1'b0;
        iv_s[0] = 1'b1; add_s[0] = 1'b1; a_s[0] = 8'd3; b_s[0] = 8'd4;
        repeat (2) @(posedge clock);
        #1 iv_s[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        exp_q0.delete();
        exp_q1.delete();
        compared++;
        if (ov_s[0] !== 1'b0 || sum_s[0] !== 8'd0 || ir_s[0] !== 1'b1 || wrap_s[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got out_valid=%0d sum=%0d in_ready=%0d wrap=%0d want 0/0/1/0",
                     ov_s[0], sum_s[0], ir_s[0], wrap_s[0]);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        or_s[0] = 1'b1;
        run_one(0, 8'd12, 8'd20, 1'b1, lat1, obs);
        compared++;
        if (lat1 !== 1'b0 || obs !== {3'b101, 8'd6}) begin
            mismatched++;
            $display("FAIL reset_recover: got early_valid=%0d ov/err/wrap/sum=%0d/%0d/%0d/%0d want 0 1/0/1/6",
                     lat1, obs[10], obs[9], obs[8], obs[7:0]);
        end
        drain();
    endtask

    task automatic test_random();
        bit hs[2] = '{0, 0};
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (!iv_s[d] || hs[d]) begin
                    iv_s[d]  = ($urandom_range(0, 3) != 0);
                    add_s[d] = 1'($urandom_range(0, 1));
                    a_s[d]   = (d == 0) ? 8'($urandom_range(0, 27)) : 8'($urandom);
                    b_s[d]   = (d == 0) ? 8'($urandom_range(0, 27)) : 8'($urandom);
                end
                or_s[d] = ($urandom_range(0, 2) != 0);
            end
            @(negedge clock);
            for (int d = 0; d < 2; d++) hs[d] = iv_s[d] && ir_s[d];
            @(posedge clock); #1;
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mod26_directed();
        test_mod0_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
